// File: rtl/board_score_keeper_if.sv
// rtl/board_score_keeper_if.sv - FSM-to-score-keeper bus: store strobes, clears, board and score outputs
interface board_score_keeper_if #(
    parameter int SCORE_W = 4
);
    logic [8:0]         almacenar_x;
    logic [8:0]         almacenar_o;
    logic               resetPosiciones;
    logic               resetScore;
    logic               inc_x_score;
    logic               inc_o_score;
    logic [8:0]         x;
    logic [8:0]         o;
    logic [3:0]         move_count;
    logic               board_full;
    logic [8:0]         win_mask;
    logic [SCORE_W-1:0] score_x;
    logic [SCORE_W-1:0] score_o;
    logic               illegal;

    // Game FSM side: issues strobes and levels, reads back board and scores
    modport master (
        output almacenar_x, almacenar_o, resetPosiciones, resetScore,
               inc_x_score, inc_o_score,
        input  x, o, move_count, board_full, win_mask, score_x, score_o, illegal
    );

    // Score keeper side
    modport slave (
        input  almacenar_x, almacenar_o, resetPosiciones, resetScore,
               inc_x_score, inc_o_score,
        output x, o, move_count, board_full, win_mask, score_x, score_o, illegal
    );
endinterface

// File: rtl/board_score_keeper.sv
// rtl/board_score_keeper.sv - tic-tac-toe board storage, legality check, win detection and scores
module board_score_keeper #(
    parameter int SCORE_MAX = 9,
    parameter int SCORE_W   = 4
) (
    input  logic                  clk_100MHz,
    input  logic                  rst_n,
    board_score_keeper_if.slave   bus
);
    // Rows, columns, then the two diagonals; bit i is square i
    localparam logic [8:0] LINES [8] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };
    localparam logic [SCORE_W-1:0] SCORE_LIMIT = SCORE_W'(SCORE_MAX);

    logic [8:0]         x_q, x_d;
    logic [8:0]         o_q, o_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               ill_q, ill_d;
    logic [8:0]         win_q, win_d;
    logic [SCORE_W-1:0] sx_q, sx_d;
    logic [SCORE_W-1:0] so_q, so_d;
    logic               incx_q, inco_q;

    // Squares covered by every line fully owned by one player
    function automatic logic [8:0] line_mask(input logic [8:0] b);
        logic [8:0] m;
        m = 9'd0;
        for (int k = 0; k < 8; k++) begin
            if ((b & LINES[k]) == LINES[k]) m = m | LINES[k];
        end
        return m;
    endfunction

    // True when more than one bit of the strobe is set
    function automatic logic multi_hot(input logic [8:0] v);
        return (v & (v - 9'd1)) != 9'd0;
    endfunction

    // Board update: clear, then rejection rules, then single legal placement
    always_comb begin
        x_d   = x_q;
        o_d   = o_q;
        cnt_d = cnt_q;
        ill_d = ill_q;
        if (bus.resetPosiciones) begin
            x_d   = 9'd0;
            o_d   = 9'd0;
            cnt_d = 4'd0;
            ill_d = 1'b0;
        end else if (bus.almacenar_x != 9'd0 && bus.almacenar_o != 9'd0) begin
            ill_d = 1'b1;
        end else if (multi_hot(bus.almacenar_x) || multi_hot(bus.almacenar_o)) begin
            ill_d = 1'b1;
        end else if (bus.almacenar_x != 9'd0) begin
            if ((bus.almacenar_x & o_q) != 9'd0) begin
                ill_d = 1'b1;
            end else if ((bus.almacenar_x & x_q) == 9'd0 && cnt_q != 4'd9) begin
                x_d   = x_q | bus.almacenar_x;
                cnt_d = cnt_q + 4'd1;
            end
        end else if (bus.almacenar_o != 9'd0) begin
            if ((bus.almacenar_o & x_q) != 9'd0) begin
                ill_d = 1'b1;
            end else if ((bus.almacenar_o & o_q) == 9'd0 && cnt_q != 4'd9) begin
                o_d   = o_q | bus.almacenar_o;
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Win mask is taken from the registered board, so it trails the board by a cycle
    always_comb begin
        win_d = line_mask(x_q) | line_mask(o_q);
    end

    // Scores count rising edges of the winner levels, saturating; resetScore wins over an edge
    always_comb begin
        sx_d = sx_q;
        so_d = so_q;
        if (bus.resetScore) begin
            sx_d = '0;
            so_d = '0;
        end else begin
            if (bus.inc_x_score && !incx_q && sx_q != SCORE_LIMIT) sx_d = sx_q + 1'b1;
            if (bus.inc_o_score && !inco_q && so_q != SCORE_LIMIT) so_d = so_q + 1'b1;
        end
    end

    // State registers; edge-detect copies track the inputs even during resetScore
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= 9'd0;
            o_q    <= 9'd0;
            cnt_q  <= 4'd0;
            ill_q  <= 1'b0;
            win_q  <= 9'd0;
            sx_q   <= '0;
            so_q   <= '0;
            incx_q <= 1'b0;
            inco_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            o_q    <= o_d;
            cnt_q  <= cnt_d;
            ill_q  <= ill_d;
            win_q  <= win_d;
            sx_q   <= sx_d;
            so_q   <= so_d;
            incx_q <= bus.inc_x_score;
            inco_q <= bus.inc_o_score;
        end
    end

    assign bus.x          = x_q;
    assign bus.o          = o_q;
    assign bus.move_count = cnt_q;
    assign bus.board_full = (cnt_q == 4'd9);
    assign bus.win_mask   = win_q;
    assign bus.score_x    = sx_q;
    assign bus.score_o    = so_q;
    assign bus.illegal    = ill_q;
endmodule

// File: tb/tb_board_score_keeper.sv
// tb/tb_board_score_keeper.sv - self-checking bench for board_score_keeper
module tb_board_score_keeper;
    logic clk_100MHz = 1'b0;
    logic rst_n      = 1'b0;
    int   n_checks   = 0;
    int   n_pass     = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    board_score_keeper_if #(.SCORE_W(4)) bus ();

    board_score_keeper #(.SCORE_MAX(9), .SCORE_W(4)) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    typedef struct {
        string      name;
        logic [8:0] ax;
        logic [8:0] ao;
        logic       rp;
        logic [8:0] ex;
        logic [8:0] eo;
        logic [3:0] ecnt;
        logic       eill;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        bus.almacenar_x     = 9'd0;
        bus.almacenar_o     = 9'd0;
        bus.resetPosiciones = 1'b0;
    endtask

    // One-cycle store: drive at negedge, sample 1 ns after the rising edge
    task automatic store(input logic [8:0] ax, input logic [8:0] ao, input logic rp);
        @(negedge clk_100MHz);
        bus.almacenar_x     = ax;
        bus.almacenar_o     = ao;
        bus.resetPosiciones = rp;
        @(posedge clk_100MHz);
        #1;
        idle_inputs();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    initial begin
        idle_inputs();
        bus.resetScore  = 1'b0;
        bus.inc_x_score = 1'b0;
        bus.inc_o_score = 1'b0;

        vecs[0] = '{"x_sq0",        9'h001, 9'h000, 1'b0, 9'h001, 9'h000, 4'd1, 1'b0};
        vecs[1] = '{"o_sq4",        9'h000, 9'h010, 1'b0, 9'h001, 9'h010, 4'd2, 1'b0};
        vecs[2] = '{"o_on_x",       9'h000, 9'h001, 1'b0, 9'h001, 9'h010, 4'd2, 1'b1};
        vecs[3] = '{"x_idem",       9'h001, 9'h000, 1'b0, 9'h001, 9'h010, 4'd2, 1'b1};
        vecs[4] = '{"clear",        9'h000, 9'h000, 1'b1, 9'h000, 9'h000, 4'd0, 1'b0};
        vecs[5] = '{"x_multihot",   9'h003, 9'h000, 1'b0, 9'h000, 9'h000, 4'd0, 1'b1};
        vecs[6] = '{"clear2",       9'h000, 9'h000, 1'b1, 9'h000, 9'h000, 4'd0, 1'b0};
        vecs[7] = '{"both_strobes", 9'h001, 9'h002, 1'b0, 9'h000, 9'h000, 4'd0, 1'b1};
        vecs[8] = '{"clear_w_store",9'h004, 9'h000, 1'b1, 9'h000, 9'h000, 4'd0, 1'b0};
        vecs[9] = '{"o_sq8",        9'h000, 9'h100, 1'b0, 9'h000, 9'h100, 4'd1, 1'b0};

        cycles(3);
        check("rst_x",     32'(bus.x), 32'h0);
        check("rst_score", 32'({bus.score_x, bus.score_o}), 32'h0);
        check("rst_ill",   32'(bus.illegal), 32'h0);
        @(negedge clk_100MHz);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            store(vecs[i].ax, vecs[i].ao, vecs[i].rp);
            check({vecs[i].name, "_x"},   32'(bus.x),          32'(vecs[i].ex));
            check({vecs[i].name, "_o"},   32'(bus.o),          32'(vecs[i].eo));
            check({vecs[i].name, "_cnt"}, 32'(bus.move_count), 32'(vecs[i].ecnt));
            check({vecs[i].name, "_ill"}, 32'(bus.illegal),    32'(vecs[i].eill));
        end

        // Top row X win, mask one cycle behind the completing store
        store(9'h000, 9'h000, 1'b1);
        store(9'h001, 9'h000, 1'b0);
        store(9'h000, 9'h008, 1'b0);
        store(9'h002, 9'h000, 1'b0);
        store(9'h000, 9'h010, 1'b0);
        store(9'h004, 9'h000, 1'b0);
        check("win_lag", 32'(bus.win_mask), 32'h0);
        cycles(1);
        check("win_row0", 32'(bus.win_mask), 32'h007);

        // X score saturation over 12 long wins
        for (int w = 0; w < 12; w++) begin
            @(negedge clk_100MHz);
            bus.inc_x_score = 1'b1;
            repeat (50) @(negedge clk_100MHz);
            bus.inc_x_score = 1'b0;
            repeat (3) @(negedge clk_100MHz);
            if (w == 0) check("score_x_once", 32'(bus.score_x), 32'd1);
        end
        check("score_x_sat", 32'(bus.score_x), 32'd9);
        check("score_o_zero", 32'(bus.score_o), 32'd0);

        // O reaches 3, then resetScore collides with a rising inc_o
        for (int w = 0; w < 3; w++) begin
            @(negedge clk_100MHz);
            bus.inc_o_score = 1'b1;
            repeat (4) @(negedge clk_100MHz);
            bus.inc_o_score = 1'b0;
            @(negedge clk_100MHz);
        end
        check("score_o_3", 32'(bus.score_o), 32'd3);
        @(negedge clk_100MHz);
        bus.inc_o_score = 1'b1;
        bus.resetScore  = 1'b1;
        @(posedge clk_100MHz);
        #1;
        check("rs_prio_o", 32'(bus.score_o), 32'd0);
        check("rs_clear_x", 32'(bus.score_x), 32'd0);
        check("rs_keeps_board", 32'(bus.x), 32'h007);
        @(negedge clk_100MHz);
        bus.resetScore = 1'b0;
        repeat (5) @(negedge clk_100MHz);
        check("rs_no_recount", 32'(bus.score_o), 32'd0);
        bus.inc_o_score = 1'b0;
        @(negedge clk_100MHz);
        bus.inc_x_score = 1'b1;
        bus.inc_o_score = 1'b1;
        @(posedge clk_100MHz);
        #1;
        check("dual_inc", 32'({bus.score_x, bus.score_o}), 32'h11);
        bus.inc_x_score = 1'b0;
        bus.inc_o_score = 1'b0;

        // Draw: X 0,2,3,7,8 / O 1,4,5,6, alternating
        store(9'h000, 9'h000, 1'b1);
        check("rp_keeps_score", 32'({bus.score_x, bus.score_o}), 32'h11);
        store(9'h001, 9'h000, 1'b0);
        store(9'h000, 9'h002, 1'b0);
        store(9'h004, 9'h000, 1'b0);
        store(9'h000, 9'h010, 1'b0);
        store(9'h008, 9'h000, 1'b0);
        store(9'h000, 9'h020, 1'b0);
        store(9'h080, 9'h000, 1'b0);
        store(9'h000, 9'h040, 1'b0);
        store(9'h100, 9'h000, 1'b0);
        check("full_cnt",  32'(bus.move_count), 32'd9);
        check("full_flag", 32'(bus.board_full), 32'd1);
        check("full_ill",  32'(bus.illegal), 32'd0);
        store(9'h001, 9'h000, 1'b0);
        check("full_idem_cnt", 32'(bus.move_count), 32'd9);
        check("draw_nowin", 32'(bus.win_mask), 32'h0);

        // Asynchronous reset between edges
        @(posedge clk_100MHz);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_board", 32'({bus.x, bus.o, bus.move_count}), 32'h0);
        check("arst_misc",  32'({bus.board_full, bus.illegal, bus.win_mask, bus.score_x, bus.score_o}), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/board_score_keeper.md
# board_score_keeper

Storage and scoring back end for the tic-tac-toe game FSM. It consumes the one-hot store strobes, board-clear and score-control levels that the FSM issues. It holds the authoritative X/O board, move count and per-player win scores, and feeds `x`/`o` back to the FSM and the board/score display logic. It checks every store for legality and flags protocol violations without corrupting the board.

## Interface
Parameters:
- `SCORE_MAX`, 9: saturation value for each player score (single 7-seg digit).
- `SCORE_W`, 4: score width; must hold `SCORE_MAX`.

Ports:
- `clk_100MHz` in 1: system clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `almacenar_x` in 9: one-hot request to place X on square i.
- `almacenar_o` in 9: one-hot request to place O on square i.
- `resetPosiciones` in 1: level; clear board.
- `resetScore` in 1: level; clear both scores.
- `inc_x_score` in 1: level, held while the X-winner state persists.
- `inc_o_score` in 1: level, held while the O-winner state persists.
- `x` out 9: squares owned by X.
- `o` out 9: squares owned by O.
- `move_count` out 4: accepted placements since last clear, 0..9.
- `board_full` out 1: `move_count == 9`.
- `win_mask` out 9: squares of every completed line (X or O); 0 if none.
- `score_x` out `SCORE_W`: X wins.
- `score_o` out `SCORE_W`: O wins.
- `illegal` out 1: sticky store-violation flag.

## Operation
- Reset (`rst_n`=0): all outputs 0, edge-detect registers 0, asynchronously.
- Board update per edge, in priority order:
  1. `resetPosiciones`=1: `x`, `o`, `move_count`, `illegal` cleared. Any store in the same cycle is discarded.
  2. Both strobes nonzero in the same cycle: no board change; `illegal` set.
  3. Strobe with more than one bit set: no change; `illegal` set.
  4. One-hot `almacenar_x` bit i:
     - Square empty: set `x[i]`, increment `move_count`.
     - `x[i]` already 1: idempotent; no count, no flag.
     - `o[i]`=1: no change; `illegal` set.
  5. `almacenar_o`: symmetric to step 4.
  6. Both strobes zero: hold.
- `move_count` never exceeds 9. If a store arrives when the count is 9, no square can be empty, so the store is rejected by the rules above.
- `win_mask` is the OR of all 8 lines (3 rows, 3 columns, 2 diagonals) fully owned by X or fully owned by O. It is registered, computed from the post-update board.
- Score logic:
  - Each of `inc_x_score`/`inc_o_score` is registered for edge detection.
  - Increment the score by 1 only on a 0→1 transition, once per win regardless of hold time.
  - Saturate at `SCORE_MAX`.
  - `resetScore`=1 clears both scores and has priority over a simultaneous increment edge.
  - The edge-detect registers keep tracking the inputs during `resetScore`, so a held `inc` does not re-count after `resetScore` releases.
- Simultaneous rising edges on both inc inputs: both scores increment.
- `resetPosiciones` does not affect scores. `resetScore` does not affect the board.

## Timing
- Store strobe sampled at edge N: `x`/`o`/`move_count`/`board_full`/`illegal` reflect it after edge N. The FSM reads the updated board in its next state.
- `win_mask` lags the board by one cycle (valid after edge N+1).
- Score change: `inc` seen high at edge N with registered copy 0 → score updates after edge N.
- `resetPosiciones`/`resetScore` take effect at the first edge they are sampled high. While held, outputs stay cleared.
- Async reset mid-game: immediate clear. On release, the first edge behaves as a normal cycle.

## Test plan
- Reset, then a one-cycle `almacenar_x`=9'h001, then `almacenar_o`=9'h010 → `x`=001, `o`=010, `move_count`=2, `illegal`=0.
- X already on square 0; `almacenar_o`=9'h001 → board unchanged, `illegal`=1. Then `almacenar_x`=9'h001 → no change, count unchanged. Then `resetPosiciones` → all board outputs and `illegal` 0.
- X stores squares 0, 1, 2 interleaved with O stores on 3, 4 → `win_mask`=9'h007 one cycle after the third X store.
- `inc_x_score` held high for 50 cycles, repeated 12 times with gaps → `score_x`=9 (saturated), `score_o`=0.
- `resetScore` pulses in the same cycle as an `inc_o_score` rising edge, with `score_o`=3 → `score_o`=0 and stays 0 while `inc_o_score` remains high.
- 9 legal alternating stores (no win) → `board_full`=1, `move_count`=9. Assert `rst_n`=0 mid-clock → all outputs 0 before the next edge.
